mmio_arbiter: RTL and testbench

Shares the single memory-mapped bus (synchronous RAM at 0x0xxx, LED register at 0x1xxx, seven-segment scroller at 0x2xxx) between two masters: the processor (master 0) and a switch-driven debug loader (master 1). Arbitrates round-robin, decodes the address region, generates the per-slave write enables and returns read data after the RAM's one-cycle latency. Sits between `proc2`/loader and the `ramlpm`/`regn`/`seg7_scroll` instances at top level.

---
 rtl/mmio_pkg.sv | 23 ++
 rtl/mmio_decode.sv | 21 ++
 rtl/mmio_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mmio_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped bus arbiter: region codes taken
// from ADDR[AW-1:AW-4], the arbiter FSM states and the region-select bundle.
package mmio_pkg;

  localparam logic [3:0] REG_MEM = 4'h0;
  localparam logic [3:0] REG_LED = 4'h1;
  localparam logic [3:0] REG_SSD = 4'h2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } mmio_state_e;

  // One-hot region select; exactly one field is set for any region code.
  typedef struct packed {
    logic mem;
    logic led;
    logic ssd;
    logic unmapped;
  } region_sel_t;

endpackage

// File: rtl/mmio_decode.sv
// Combinational region decoder: 4-bit region code -> one-hot
// {mem, led, ssd, unmapped}. Reusable by the top level for read muxing.
module mmio_decode
  import mmio_pkg::*;
(
  input  logic [3:0]  region,
  output region_sel_t sel
);

  // Map the three populated regions; everything else is unmapped.
  always_comb begin
    sel = '0;
    case (region)
      REG_MEM: sel.mem = 1'b1;
      REG_LED: sel.led = 1'b1;
      REG_SSD: sel.ssd = 1'b1;
      default: sel.unmapped = 1'b1;
    endcase
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter for the shared memory-mapped bus.
//
// Handshake: a master raises ReqN with ADDRN/DOUTN/WN and holds all four
// stable until it sees the one-cycle AckN pulse; DINN is valid in that Ack
// cycle. A new request (or a dropped Req) may follow from the next cycle.
// Once a transfer has been issued it always completes, whatever Req does.
//
// Transfer shape: IDLE (arbitrate) -> ISSUE (bus driven, write enable) ->
// RESP (Ack, read data from the RAM's registered output) -> IDLE.
//
// Optional feature macro MMIO_ERR_EN: records the first access to an
// unmapped region in ERR / ERR_ADDR. Without it both outputs are tied to 0.
module mmio_arbiter
  import mmio_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Req0,
  input  logic          Req1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] DOUT0,
  input  logic [DW-1:0] DOUT1,
  input  logic          W0,
  input  logic          W1,
  output logic          Ack0,
  output logic          Ack1,
  output logic [DW-1:0] DIN0,
  output logic [DW-1:0] DIN1,
  output logic [1:0]    Gnt,
  output logic [AW-1:0] BUS_ADDR,
  output logic [DW-1:0] BUS_DOUT,
  output logic          MEMen,
  output logic          LEDen,
  output logic          SSDen,
  input  logic [DW-1:0] MEM_DIN,
  output logic          ERR,
  output logic [AW-1:0] ERR_ADDR,
  output mmio_state_e   dbg_state
);

  mmio_state_e   state_q, state_d;
  logic          last_q, last_d;     // master granted most recently
  logic          owner_q, owner_d;   // master owning the current transfer
  logic          wr_q, wr_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_dout_q, bus_dout_d;
  logic [DW-1:0] din0_q, din0_d;
  logic [DW-1:0] din1_q, din1_d;

  logic          winner;
  logic          in_issue;
  logic          in_resp;
  logic [DW-1:0] rd_data;
  region_sel_t   sel;

  mmio_decode u_decode (
    .region (bus_addr_q[AW-1:AW-4]),
    .sel    (sel)
  );

  // On contention the master not granted last wins; otherwise the sole requester.
  assign winner = (Req0 && Req1) ? ~last_q : Req1;

  assign in_issue = (state_q == ST_ISSUE);
  assign in_resp  = (state_q == ST_RESP);

  // LED and seven-segment slaves are write-only, so only RAM returns data.
  assign rd_data = sel.mem ? MEM_DIN : '0;

  // Next-state and capture logic for the transfer sequence.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    bus_addr_d = bus_addr_q;
    bus_dout_d = bus_dout_q;
    din0_d     = din0_q;
    din1_d     = din1_q;
    case (state_q)
      ST_IDLE: begin
        if (Req0 || Req1) begin
          state_d    = ST_ISSUE;
          owner_d    = winner;
          last_d     = winner;
          bus_addr_d = winner ? ADDR1 : ADDR0;
          bus_dout_d = winner ? DOUT1 : DOUT0;
          wr_d       = winner ? W1 : W0;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP: begin
        state_d = ST_IDLE;
        if (!wr_q) begin
          if (owner_q) din1_d = rd_data;
          else         din0_d = rd_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset leaves master 0 with priority.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      bus_addr_q <= '0;
      bus_dout_q <= '0;
      din0_q     <= '0;
      din1_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      bus_addr_q <= bus_addr_d;
      bus_dout_q <= bus_dout_d;
      din0_q     <= din0_d;
      din1_q     <= din1_d;
    end
  end

  assign BUS_ADDR  = bus_addr_q;
  assign BUS_DOUT  = bus_dout_q;
  assign MEMen     = in_issue & wr_q & sel.mem;
  assign LEDen     = in_issue & wr_q & sel.led;
  assign SSDen     = in_issue & wr_q & sel.ssd;
  assign Ack0      = in_resp & ~owner_q;
  assign Ack1      = in_resp & owner_q;
  assign Gnt       = (state_q == ST_IDLE) ? 2'b00 : {owner_q, ~owner_q};
  // Read data is presented in the Ack cycle and then held until the next read.
  assign DIN0      = din0_d;
  assign DIN1      = din1_d;
  assign dbg_state = state_q;

`ifdef MMIO_ERR_EN
  logic          err_q, err_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  // Latch only the first unmapped access; later ones leave the record alone.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (in_issue && sel.unmapped && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = bus_addr_q;
    end
  end

  // Sticky error record, cleared only by reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign ERR      = err_q;
  assign ERR_ADDR = err_addr_q;
`else
  logic unused_unmapped;
  assign unused_unmapped = sel.unmapped;
  assign ERR      = 1'b0;
  assign ERR_ADDR = '0;
`endif

endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: directed scenarios followed by randomized traffic
// from two masters, all checked each cycle against a transaction-level model.
module tb_mmio_arbiter;
  import mmio_pkg::*;

`ifdef MMIO_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        Clock, Resetn;
  logic        Req0, Req1, W0, W1;
  logic [15:0] ADDR0, ADDR1, DOUT0, DOUT1;
  logic        Ack0, Ack1, MEMen, LEDen, SSDen, ERR;
  logic [15:0] DIN0, DIN1, BUS_ADDR, BUS_DOUT, MEM_DIN, ERR_ADDR;
  logic [1:0]  Gnt;
  mmio_state_e dbg_state;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  mmio_arbiter #(.AW(16), .DW(16)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .Req0(Req0), .Req1(Req1), .ADDR0(ADDR0), .ADDR1(ADDR1),
    .DOUT0(DOUT0), .DOUT1(DOUT1), .W0(W0), .W1(W1),
    .Ack0(Ack0), .Ack1(Ack1), .DIN0(DIN0), .DIN1(DIN1), .Gnt(Gnt),
    .BUS_ADDR(BUS_ADDR), .BUS_DOUT(BUS_DOUT),
    .MEMen(MEMen), .LEDen(LEDen), .SSDen(SSDen), .MEM_DIN(MEM_DIN),
    .ERR(ERR), .ERR_ADDR(ERR_ADDR), .dbg_state(dbg_state)
  );

  // Small synchronous RAM slave with registered read data.
  logic [15:0] ram [16];
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
      MEM_DIN <= '0;
    end else begin
      if (MEMen) ram[BUS_ADDR[3:0]] <= BUS_DOUT;
      MEM_DIN <= ram[BUS_ADDR[3:0]];
    end
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        w;
  } req_t;

  typedef struct {
    int          c;
    int          m;
    logic [15:0] din;
    logic [1:0]  gnt;
  } ack_rec_t;

  typedef struct {
    int   c;
    logic mem;
    logic led;
    logic ssd;
  } en_rec_t;

  req_t     q0[$], q1[$];
  ack_rec_t ack_log[$];
  en_rec_t  en_log[$];
  logic     pend [2];
  int       pres_pct;
  bit       drop_en;

  // ---------------- transaction-level model ----------------
  logic        m_busy;
  int          m_issue;      // cycle in which the current transfer is on the bus
  logic        m_m;
  req_t        m_cur;
  logic        m_last;
  logic [15:0] m_mem [16];
  logic [15:0] m_bus_addr, m_bus_dout;
  logic [15:0] m_din [2];
  logic        m_err;
  logic [15:0] m_err_addr;
  int          cur_phase;    // 0 idle, 1 issue, 2 response

  task automatic model_reset();
    m_busy = 1'b0; m_issue = 0; m_m = 1'b0; m_cur = '0; m_last = 1'b1;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_bus_addr = '0; m_bus_dout = '0;
    m_din[0] = '0; m_din[1] = '0;
    m_err = 1'b0; m_err_addr = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    logic [3:0] rg;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: rg = 4'h0;
      5, 6:          rg = 4'h1;
      7:             rg = 4'h2;
      default:       rg = 4'($urandom_range(3, 15));
    endcase
    if (rg == 4'h0) r.addr = {4'h0, 8'h00, 4'($urandom_range(0, 15))};
    else            r.addr = {rg, 12'($urandom_range(0, 4095))};
    r.data = 16'($urandom_range(0, 65535));
    r.w    = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic set_bus(input int m, input logic req, input req_t r);
    if (m == 0) begin Req0 = req; ADDR0 = r.addr; DOUT0 = r.data; W0 = r.w; end
    else        begin Req1 = req; ADDR1 = r.addr; DOUT1 = r.data; W1 = r.w; end
  endtask

  task automatic drive_master(input int m, input logic ack);
    req_t r;
    bit   go;
    if (!Resetn) begin
      pend[m] = 1'b0;
      set_bus(m, 1'b0, rand_req());
      return;
    end
    if (pend[m] && ack) pend[m] = 1'b0;
    if (pend[m]) begin
      // Once issued, a master may let go of its request early.
      if (drop_en && cur_phase == 1 && m_m == m[0] && $urandom_range(0, 3) == 0)
        set_bus(m, 1'b0, rand_req());
      return;
    end
    go = 0;
    r  = '0;
    if (m == 0 && q0.size() > 0 && $urandom_range(1, 100) <= pres_pct) begin
      r = q0.pop_front(); go = 1;
    end
    if (m == 1 && q1.size() > 0 && $urandom_range(1, 100) <= pres_pct) begin
      r = q1.pop_front(); go = 1;
    end
    if (go) begin
      pend[m] = 1'b1;
      set_bus(m, 1'b1, r);
    end else begin
      set_bus(m, 1'b0, rand_req());
    end
  endtask

  // Model reaction to the rising edge that ends the current cycle.
  task automatic advance();
    if (m_busy && cyc == m_issue) begin
      if (m_cur.w && m_cur.addr[15:12] == 4'h0) m_mem[m_cur.addr[3:0]] = m_cur.data;
`ifdef MMIO_ERR_EN
      if (m_cur.addr[15:12] > 4'h2 && !m_err) begin
        m_err = 1'b1;
        m_err_addr = m_cur.addr;
      end
`endif
    end else if (m_busy && cyc == m_issue + 1) begin
      m_busy = 1'b0;
    end else if (!m_busy && (Req0 || Req1)) begin
      if (Req0 && Req1) m_m = (m_last == 1'b0) ? 1'b1 : 1'b0;
      else if (Req0)    m_m = 1'b0;
      else              m_m = 1'b1;
      m_cur      = m_m ? {ADDR1, DOUT1, W1} : {ADDR0, DOUT0, W0};
      m_issue    = cyc + 1;
      m_busy     = 1'b1;
      m_last     = m_m;
      m_bus_addr = m_cur.addr;
      m_bus_dout = m_cur.data;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  task automatic step();
    logic [1:0]  e_gnt;
    logic        e_ack0, e_ack1, e_mem, e_led, e_ssd, a0, a1;
    logic [3:0]  rg;
    mmio_state_e e_st;
    @(negedge Clock);
    cyc++;
    cur_phase = 0;
    if (m_busy && cyc == m_issue)          cur_phase = 1;
    else if (m_busy && cyc == m_issue + 1) cur_phase = 2;
    rg = m_cur.addr[15:12];
    e_gnt = 2'b00; e_ack0 = 0; e_ack1 = 0; e_mem = 0; e_led = 0; e_ssd = 0;
    e_st = ST_IDLE;
    if (cur_phase != 0) e_gnt = m_m ? 2'b10 : 2'b01;
    if (cur_phase == 1) begin
      e_st  = ST_ISSUE;
      e_mem = m_cur.w && rg == 4'h0;
      e_led = m_cur.w && rg == 4'h1;
      e_ssd = m_cur.w && rg == 4'h2;
    end
    if (cur_phase == 2) begin
      e_st = ST_RESP;
      if (m_m) e_ack1 = 1'b1; else e_ack0 = 1'b1;
      if (!m_cur.w) m_din[m_m] = (rg == 4'h0) ? m_mem[m_cur.addr[3:0]] : 16'h0;
    end
    chk("gnt",      32'(Gnt),       32'(e_gnt));
    chk("ack0",     32'(Ack0),      32'(e_ack0));
    chk("ack1",     32'(Ack1),      32'(e_ack1));
    chk("memen",    32'(MEMen),     32'(e_mem));
    chk("leden",    32'(LEDen),     32'(e_led));
    chk("ssden",    32'(SSDen),     32'(e_ssd));
    chk("bus_addr", 32'(BUS_ADDR),  32'(m_bus_addr));
    chk("bus_dout", 32'(BUS_DOUT),  32'(m_bus_dout));
    chk("din0",     32'(DIN0),      32'(m_din[0]));
    chk("din1",     32'(DIN1),      32'(m_din[1]));
    chk("err",      32'(ERR),       32'(m_err));
    chk("err_addr", 32'(ERR_ADDR),  32'(m_err_addr));
    chk("state",    32'(dbg_state), 32'(e_st));
    a0 = Ack0;
    a1 = Ack1;
    if (a0) ack_log.push_back('{c: cyc, m: 0, din: DIN0, gnt: Gnt});
    if (a1) ack_log.push_back('{c: cyc, m: 1, din: DIN1, gnt: Gnt});
    if (MEMen || LEDen || SSDen) en_log.push_back('{c: cyc, mem: MEMen, led: LEDen, ssd: SSDen});
    drive_master(0, a0);
    drive_master(1, a1);
    if (Resetn) advance();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    bit idle;
    n = 0;
    idle = 0;
    while (n < budget && !idle) begin
      step();
      n++;
      idle = !m_busy && !pend[0] && !pend[1] && q0.size() == 0 && q1.size() == 0;
    end
    chk(name, 32'(idle), 32'd1);
  endtask

  // ---------------- sequencer ----------------
  initial begin : main
    int t0;
    int exp_m [4];
    Resetn = 1'b0;
    Req0 = 0; Req1 = 0; ADDR0 = '0; ADDR1 = '0; DOUT0 = '0; DOUT1 = '0; W0 = 0; W1 = 0;
    pres_pct = 100;
    drop_en  = 0;
    model_reset();
    repeat (3) step();
    Resetn = 1'b1;

    // Reset values.
    chk("rst_gnt",      32'(Gnt),       32'h0);
    chk("rst_ack0",     32'(Ack0),      32'h0);
    chk("rst_memen",    32'(MEMen),     32'h0);
    chk("rst_bus_addr", 32'(BUS_ADDR),  32'h0);
    chk("rst_din0",     32'(DIN0),      32'h0);
    chk("rst_err",      32'(ERR),       32'h0);
    chk("rst_state",    32'(dbg_state), 32'(ST_IDLE));

    // Master 0 writes RAM then reads it back.
    ack_log.delete(); en_log.delete();
    t0 = cyc;
    q0.push_back('{addr: 16'h0005, data: 16'h1234, w: 1'b1});
    q0.push_back('{addr: 16'h0005, data: 16'h0000, w: 1'b0});
    wait_idle(40, "b_idle");
    chk("b_acks", 32'(ack_log.size()), 32'd2);
    chk("b_ens",  32'(en_log.size()),  32'd1);
    if (en_log.size() >= 1) begin
      chk("b_memen",     32'(en_log[0].mem), 32'd1);
      chk("b_leden",     32'(en_log[0].led), 32'd0);
      chk("b_en_cycle",  32'(en_log[0].c),   32'(t0 + 2));
    end
    if (ack_log.size() >= 2) begin
      chk("b_ack_cycle", 32'(ack_log[0].c),   32'(t0 + 3));
      chk("b_rd_master", 32'(ack_log[1].m),   32'd0);
      chk("b_rd_data",   32'(ack_log[1].din), 32'h1234);
    end

    // Master 1: RAM read, LED write, LED read (returns 0).
    ack_log.delete(); en_log.delete();
    q1.push_back('{addr: 16'h0005, data: 16'h0000, w: 1'b0});
    q1.push_back('{addr: 16'h1000, data: 16'h00FF, w: 1'b1});
    q1.push_back('{addr: 16'h1000, data: 16'h0000, w: 1'b0});
    wait_idle(40, "c_idle");
    chk("c_acks", 32'(ack_log.size()), 32'd3);
    chk("c_ens",  32'(en_log.size()),  32'd1);
    if (en_log.size() >= 1) begin
      chk("c_leden", 32'(en_log[0].led), 32'd1);
      chk("c_memen", 32'(en_log[0].mem), 32'd0);
      chk("c_ssden", 32'(en_log[0].ssd), 32'd0);
    end
    if (ack_log.size() >= 3) begin
      chk("c_ram_rd",  32'(ack_log[0].din), 32'h1234);
      chk("c_gnt",     32'(ack_log[0].gnt), 32'h2);
      chk("c_led_rd",  32'(ack_log[2].din), 32'h0);
    end

    // Unmapped accesses.
    ack_log.delete(); en_log.delete();
    q0.push_back('{addr: 16'h3ABC, data: 16'h5555, w: 1'b1});
    q0.push_back('{addr: 16'h4000, data: 16'h0000, w: 1'b0});
    wait_idle(40, "e_idle");
    chk("e_ens",  32'(en_log.size()),  32'd0);
    chk("e_acks", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() >= 2) chk("e_rd_data", 32'(ack_log[1].din), 32'h0);
    chk("e_err",      32'(ERR),      32'(ERR_ON));
    chk("e_err_addr", 32'(ERR_ADDR), ERR_ON ? 32'h3ABC : 32'h0);

    // Reset during the ISSUE cycle of a write.
    q1.push_back('{addr: 16'h2000, data: 16'hBEEF, w: 1'b1});
    for (int i = 0; i < 8 && cur_phase != 1; i++) step();
    chk("f_in_issue", 32'(cur_phase), 32'd1);
    chk("f_ssden_hi", 32'(SSDen),     32'd1);
    #1;
    Resetn = 1'b0;
    q0.delete(); q1.delete();
    model_reset();
    #1;
    chk("f_ssden_lo", 32'(SSDen),     32'd0);
    chk("f_ack1",     32'(Ack1),      32'd0);
    chk("f_gnt",      32'(Gnt),       32'd0);
    chk("f_state",    32'(dbg_state), 32'(ST_IDLE));
    repeat (3) step();
    Resetn = 1'b1;

    // Both masters requesting back to back: grants alternate from master 0.
    ack_log.delete(); en_log.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{addr: 16'(i), data: 16'h0000, w: 1'b0});
      q1.push_back('{addr: 16'(i), data: 16'(16'hA000 + i), w: 1'b1});
    end
    wait_idle(100, "d_idle");
    exp_m[0] = 0; exp_m[1] = 1; exp_m[2] = 0; exp_m[3] = 1;
    chk("d_acks", 32'(ack_log.size()), 32'd8);
    if (ack_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("d_master", 32'(ack_log[i].m), 32'(exp_m[i]));
        if (i > 0) chk("d_spacing", 32'(ack_log[i].c - ack_log[i-1].c), 32'd3);
      end
      chk("d_gnt0", 32'(ack_log[0].gnt), 32'h1);
      chk("d_gnt1", 32'(ack_log[1].gnt), 32'h2);
    end

    // Randomized traffic with gaps and early Req release.
    pres_pct = 60;
    drop_en  = 1;
    for (int i = 0; i < 150; i++) begin
      q0.push_back(rand_req());
      q1.push_back(rand_req());
    end
    wait_idle(4000, "r_idle");
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
